// File: rtl/apb_slv_pkg.sv
// Shared types for the APB register-file completer.
// Holds the FSM state enum, the status word offset and the error codes.
package apb_slv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_ALIGN = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;
  localparam logic [1:0] ERR_RO    = 2'd3;

  // Status word sits directly after the last RW register.
  function automatic int unsigned status_offset(
    input int unsigned num_regs
  );
    return num_regs * 4;
  endfunction

endpackage

// File: rtl/apb_slv_addr_decode.sv
// Address decoder for the APB register-file completer (combinational).
// Ports: addr/write in; hit_rw, hit_status, idx, err out.
module apb_slv_addr_decode #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS   = 8,
  parameter int IDX_W      = 3
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  write,
  output logic                  hit_rw,
  output logic                  hit_status,
  output logic [IDX_W-1:0]      idx,
  output logic                  err
);
  import apb_slv_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] STAT =
    ADDR_WIDTH'(status_offset(NUM_REGS));

  logic       misal;
  logic [1:0] err_code;

  assign misal = (addr[1:0] != 2'b00);
  assign idx   = addr[2 +: IDX_W];
  assign err   = (err_code != ERR_NONE);

  always_comb begin
    err_code   = ERR_NONE;
    hit_rw     = 1'b0;
    hit_status = 1'b0;
    unique case (1'b1)
      misal:
        err_code = ERR_ALIGN;
      !misal && (addr > STAT):
        err_code = ERR_RANGE;
      !misal && (addr == STAT) && write:
        err_code = ERR_RO;
      !misal && (addr == STAT) && !write:
        hit_status = 1'b1;
      default:
        hit_rw = 1'b1;
    endcase
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB3 completer with NUM_REGS RW registers and one RO status word.
// Ports: APB (psel/penable/pwrite/paddr/pwdata -> prdata/pready/pslverr),
// i_status in, o_regs flat out, o_wr_pulse/o_wr_idx write strobe.
module apb_slave_regfile #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                           i_clk_apb,
  input  logic                           i_rst_apb,
  input  logic                           i_psel,
  input  logic                           i_penable,
  input  logic                           i_pwrite,
  input  logic [ADDR_WIDTH-1:0]          i_paddr,
  input  logic [DATA_WIDTH-1:0]          i_pwdata,
  output logic [DATA_WIDTH-1:0]          o_prdata,
  output logic                           o_pready,
  output logic                           o_pslverr,
  input  logic [DATA_WIDTH-1:0]          i_status,
  output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs,
  output logic                           o_wr_pulse,
  output logic [$clog2(NUM_REGS)-1:0]    o_wr_idx
);
  import apb_slv_pkg::*;

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int CNT_W = 4;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    write_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [CNT_W-1:0]        cnt;
  logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

  logic [ADDR_WIDTH-1:0]   dec_addr;
  logic                    dec_write;
  logic                    hit_rw;
  logic                    hit_status;
  logic [IDX_W-1:0]        idx;
  logic                    err;
  logic [DATA_WIDTH-1:0]   rd_data;

  // In IDLE the decoder sees the live setup so a zero-wait transfer can
  // answer on the setup edge; afterwards it sees the latched transfer.
  assign dec_addr  = (state == IDLE) ? i_paddr  : addr_q;
  assign dec_write = (state == IDLE) ? i_pwrite : write_q;

  apb_slv_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_dec (
    .addr       (dec_addr),
    .write      (dec_write),
    .hit_rw     (hit_rw),
    .hit_status (hit_status),
    .idx        (idx),
    .err        (err)
  );

  always_comb begin
    rd_data = '0;
    if (!dec_write && !err) begin
      if (hit_status)  rd_data = i_status;
      else if (hit_rw) rd_data = regs[idx];
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
    assign o_regs[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
  end

  always_ff @(posedge i_clk_apb) begin
    if (i_rst_apb) begin
      state      <= IDLE;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      cnt        <= '0;
      o_prdata   <= '0;
      o_pready   <= 1'b0;
      o_pslverr  <= 1'b0;
      o_wr_pulse <= 1'b0;
      o_wr_idx   <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else begin
      o_wr_pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_psel && !i_penable) begin
            addr_q  <= i_paddr;
            write_q <= i_pwrite;
            wdata_q <= i_pwdata;
            if (WAIT_CYCLES == 0) begin
              state     <= READY;
              o_pready  <= 1'b1;
              o_pslverr <= err;
              o_prdata  <= rd_data;
            end else begin
              cnt   <= CNT_W'(WAIT_CYCLES - 1);
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!i_psel) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state     <= READY;
            o_pready  <= 1'b1;
            o_pslverr <= err;
            o_prdata  <= rd_data;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        READY: begin
          // Dropping psel here abandons the transfer without a commit.
          if (!i_psel || i_penable) begin
            if (i_psel && write_q && !err && hit_rw) begin
              regs[idx]  <= wdata_q;
              o_wr_pulse <= 1'b1;
              o_wr_idx   <= idx;
            end
            state     <= IDLE;
            o_pready  <= 1'b0;
            o_pslverr <= 1'b0;
            o_prdata  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench for apb_slave_regfile.
// Three instances with 0, 2 and 3 wait states share one clock.
module tb_apb_slave_regfile;

  localparam int NR = 8;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int ND = 3;

  typedef logic [NR*DW-1:0] wide_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst     [ND];
  logic          psel    [ND];
  logic          penable [ND];
  logic          pwrite  [ND];
  logic [AW-1:0] paddr   [ND];
  logic [DW-1:0] pwdata  [ND];
  logic [DW-1:0] status  [ND];
  logic [DW-1:0] prdata  [ND];
  logic          pready  [ND];
  logic          pslverr [ND];
  wide_t         regs_o  [ND];
  logic          wr_pulse[ND];
  logic [2:0]    wr_idx  [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    apb_slave_regfile #(
      .DATA_WIDTH  (DW),
      .ADDR_WIDTH  (AW),
      .NUM_REGS    (NR),
      .WAIT_CYCLES (g == 0 ? 0 : (g == 1 ? 2 : 3))
    ) dut (
      .i_clk_apb  (clk),
      .i_rst_apb  (rst[g]),
      .i_psel     (psel[g]),
      .i_penable  (penable[g]),
      .i_pwrite   (pwrite[g]),
      .i_paddr    (paddr[g]),
      .i_pwdata   (pwdata[g]),
      .o_prdata   (prdata[g]),
      .o_pready   (pready[g]),
      .o_pslverr  (pslverr[g]),
      .i_status   (status[g]),
      .o_regs     (regs_o[g]),
      .o_wr_pulse (wr_pulse[g]),
      .o_wr_idx   (wr_idx[g])
    );
  end

  // Reference model: register contents and the expected write strobe.
  logic [DW-1:0] m_regs [ND][NR];
  bit            exp_pulse [ND];
  logic [2:0]    exp_idx   [ND];

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  function automatic int waits(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
  endfunction

  task automatic chk(input string name, input wide_t act, input wide_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic wide_t model_regs(input int d);
    wide_t v;
    v = '0;
    for (int k = 0; k < NR; k++) v[k*DW +: DW] = m_regs[d][k];
    return v;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        for (int d = 0; d < ND; d++) begin
          chk($sformatf("regs%0d", d), regs_o[d], model_regs(d));
          chk($sformatf("wr_pulse%0d", d),
              wide_t'(wr_pulse[d]), wide_t'(exp_pulse[d]));
          if (exp_pulse[d])
            chk($sformatf("wr_idx%0d", d),
                wide_t'(wr_idx[d]), wide_t'(exp_idx[d]));
          exp_pulse[d] = 1'b0;
        end
      end
    end
  end

  // Full transfer; called just after a rising edge, returns likewise.
  task automatic xfer(input int d, input bit wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd,
                      output logic [DW-1:0] rd, output logic er);
    bit            e_err;
    logic [DW-1:0] e_rd;
    int            n;
    bit            done;
    e_err = (a[1:0] != 2'b00) || (a > NR*4) || (wr && a == NR*4);
    if (wr || e_err)   e_rd = '0;
    else if (a == NR*4) e_rd = status[d];
    else               e_rd = m_regs[d][a[4:2]];
    psel[d] = 1'b1; penable[d] = 1'b0;
    pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    n = 0; done = 1'b0;
    while (!done && n <= 20) begin
      @(negedge clk);
      if (pready[d]) done = 1'b1;
      else begin n++; @(posedge clk); #1; end
    end
    if (!done) begin
      chk("pready_timeout", wide_t'(0), wide_t'(1));
      psel[d] = 1'b0; penable[d] = 1'b0;
      rd = '0; er = 1'b1;
      return;
    end
    chk("wait_states", wide_t'(n), wide_t'(waits(d)));
    chk("prdata", wide_t'(prdata[d]), wide_t'(e_rd));
    chk("pslverr", wide_t'(pslverr[d]), wide_t'(e_err));
    rd = prdata[d]; er = pslverr[d];
    @(posedge clk); #1;
    if (wr && !e_err) begin
      m_regs[d][a[4:2]] = wd;
      exp_pulse[d] = 1'b1;
      exp_idx[d] = a[4:2];
    end
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  task automatic xfer_abort(input int d, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd);
    psel[d] = 1'b1; penable[d] = 1'b0;
    pwrite[d] = 1'b1; paddr[d] = a; pwdata[d] = wd;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    @(negedge clk);
    chk("abort_pready_wait", wide_t'(pready[d]), wide_t'(0));
    @(posedge clk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("abort_pready", wide_t'(pready[d]), wide_t'(0));
    end
    @(posedge clk); #1;
  endtask

  task automatic xfer_reset(input int d, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd);
    psel[d] = 1'b1; penable[d] = 1'b0;
    pwrite[d] = 1'b1; paddr[d] = a; pwdata[d] = wd;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    @(posedge clk); #1;
    rst[d] = 1'b1;
    @(posedge clk); #1;
    rst[d] = 1'b0;
    psel[d] = 1'b0; penable[d] = 1'b0;
    for (int k = 0; k < NR; k++) m_regs[d][k] = '0;
    exp_pulse[d] = 1'b0;
    @(negedge clk);
    chk("rst_mid_pready", wide_t'(pready[d]), wide_t'(0));
    chk("rst_mid_pslverr", wide_t'(pslverr[d]), wide_t'(0));
    chk("rst_mid_prdata", wide_t'(prdata[d]), wide_t'(0));
    chk("rst_mid_regs", regs_o[d], wide_t'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rd;
    logic          er;
    for (int d = 0; d < ND; d++) begin
      rst[d] = 1'b1; psel[d] = 1'b0; penable[d] = 1'b0;
      pwrite[d] = 1'b0; paddr[d] = '0; pwdata[d] = '0;
      status[d] = '0; exp_pulse[d] = 1'b0; exp_idx[d] = '0;
      for (int k = 0; k < NR; k++) m_regs[d][k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) rst[d] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      chk("rst_pready", wide_t'(pready[d]), wide_t'(0));
      chk("rst_pslverr", wide_t'(pslverr[d]), wide_t'(0));
      chk("rst_prdata", wide_t'(prdata[d]), wide_t'(0));
      chk("rst_wr_pulse", wide_t'(wr_pulse[d]), wide_t'(0));
      chk("rst_wr_idx", wide_t'(wr_idx[d]), wide_t'(0));
      chk("rst_regs", regs_o[d], wide_t'(0));
    end
    cmp_en = 1'b1;
    @(posedge clk); #1;

    // Zero-wait read of an untouched register.
    xfer(0, 1'b0, 32'h00, 32'h0, rd, er);
    chk("t1_rd", wide_t'(rd), wide_t'(32'h0));

    // Write then back-to-back read.
    xfer(0, 1'b1, 32'h04, 32'hDEADBEEF, rd, er);
    chk("t2_regs1", wide_t'(regs_o[0][63:32]), wide_t'(32'hDEADBEEF));
    xfer(0, 1'b0, 32'h04, 32'h0, rd, er);
    chk("t2_rd", wide_t'(rd), wide_t'(32'hDEADBEEF));

    // Two wait states.
    xfer(1, 1'b1, 32'h08, 32'h12345678, rd, er);
    chk("t3_regs2", wide_t'(regs_o[1][95:64]), wide_t'(32'h12345678));
    xfer(1, 1'b0, 32'h08, 32'h0, rd, er);
    chk("t3_rd", wide_t'(rd), wide_t'(32'h12345678));

    // Error responses.
    xfer(0, 1'b1, 32'h40, 32'h55555555, rd, er);
    chk("t4_range_err", wide_t'(er), wide_t'(1));
    xfer(0, 1'b1, 32'h06, 32'h66666666, rd, er);
    chk("t4_align_err", wide_t'(er), wide_t'(1));
    xfer(0, 1'b0, 32'h04, 32'h0, rd, er);
    chk("t4_rd", wide_t'(rd), wide_t'(32'hDEADBEEF));
    xfer(0, 1'b0, 32'h24, 32'h0, rd, er);
    chk("t4_above_status", wide_t'(er), wide_t'(1));
    xfer(0, 1'b0, 32'h22, 32'h0, rd, er);
    chk("t4_misal_rd", wide_t'(er), wide_t'(1));

    // Status word and last RW register.
    status[0] = 32'h0000A5A5;
    xfer(0, 1'b0, 32'h20, 32'h0, rd, er);
    chk("t5_status", wide_t'(rd), wide_t'(32'h0000A5A5));
    xfer(0, 1'b1, 32'h20, 32'h77777777, rd, er);
    chk("t5_ro_err", wide_t'(er), wide_t'(1));
    xfer(0, 1'b1, 32'h1C, 32'hCAFEF00D, rd, er);
    xfer(0, 1'b0, 32'h1C, 32'h0, rd, er);
    chk("t5_last_reg", wide_t'(rd), wide_t'(32'hCAFEF00D));
    status[1] = 32'h5A5A0000;
    xfer(1, 1'b0, 32'h20, 32'h0, rd, er);
    chk("t5_status_wait", wide_t'(rd), wide_t'(32'h5A5A0000));

    // Reset and abort during wait states.
    xfer(2, 1'b1, 32'h00, 32'hAAAA5555, rd, er);
    xfer_reset(2, 32'h0C, 32'hFFFFFFFF);
    xfer(2, 1'b1, 32'h0C, 32'hFFFFFFFF, rd, er);
    chk("t6_regs3", wide_t'(regs_o[2][127:96]), wide_t'(32'hFFFFFFFF));
    xfer(2, 1'b0, 32'h00, 32'h0, rd, er);
    chk("t6_reg0_cleared", wide_t'(rd), wide_t'(32'h0));
    xfer_abort(2, 32'h10, 32'h11112222);
    xfer(2, 1'b0, 32'h10, 32'h0, rd, er);
    chk("t6_abort_rd", wide_t'(rd), wide_t'(32'h0));

    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- APB3 completer (slave) for the far side of the APB master bridge: accepts setup/access transfers on psel/penable and answers with prdata/pready/pslverr.
- Contains NUM_REGS read/write 32-bit control registers, exported flat to fabric logic, and one read-only status word sampled from fabric.
- Programmable wait states; unmapped, misaligned or read-only-violating accesses answer with an error response.

Parameters:
DATA_WIDTH, 32, pwdata/prdata width
ADDR_WIDTH, 32, paddr width
NUM_REGS, 8, number of RW registers at byte offsets 0x00..(NUM_REGS-1)*4
WAIT_CYCLES, 0, wait states inserted per transfer (0..15)

Ports:
i_clk_apb  in  1  APB clock
i_rst_apb  in  1  synchronous active-high reset
i_psel  in  1  slave select
i_penable  in  1  access phase
i_pwrite  in  1  1=write, 0=read
i_paddr  in  ADDR_WIDTH  byte address, window based at 0
i_pwdata  in  DATA_WIDTH  write data
o_prdata  out  DATA_WIDTH  read data, valid when o_pready=1
o_pready  out  1  transfer completes this cycle
o_pslverr  out  1  error response, valid when o_pready=1
i_status  in  DATA_WIDTH  RO status word at offset NUM_REGS*4
o_regs  out  NUM_REGS*DATA_WIDTH  RW register contents; reg k occupies bits [k*32 +: 32]
o_wr_pulse  out  1  one-cycle pulse when a RW register is written
o_wr_idx  out  $clog2(NUM_REGS)  index of the written register, valid with o_wr_pulse

Behaviour:
- Reset (synchronous, high): state=IDLE; o_prdata=0, o_pready=0, o_pslverr=0, o_wr_pulse=0, o_wr_idx=0; all registers 0; wait counter 0.
- All outputs are registered.
- FSM states: IDLE, WAIT, READY.
- IDLE:
  - On setup (psel=1, penable=0): latch paddr, pwrite, pwdata; decode the error flag.
  - If WAIT_CYCLES=0, go to READY. Otherwise load cnt=WAIT_CYCLES-1 and go to WAIT.
  - penable=1 without a preceding setup is ignored; pready stays 0.
- WAIT:
  - If psel=0 (aborted transfer), go to IDLE with no side effects.
  - Else if cnt=0, go to READY. Else decrement cnt.
- Entry into READY: on the same edge, load o_pready=1, o_pslverr=err, and o_prdata.
  - o_prdata = selected register or i_status (sampled at that edge) for a read with no error.
  - o_prdata = 0 for writes and for errors.
- READY (psel=penable=1, pready=1):
  - The completing edge commits a write if err=0 and the target is RW.
  - That edge also drives o_wr_pulse=1 and o_wr_idx, then returns to IDLE clearing o_pready, o_pslverr and o_prdata.
- Latency: the access phase lasts WAIT_CYCLES+1 cycles. Back-to-back transfers: a new setup immediately after completion is accepted in IDLE with no gap.
- o_regs updates the cycle after the completing edge, coinciding with o_wr_pulse.
- Error conditions (err=1):
  - paddr[1:0]≠0.
  - paddr > NUM_REGS*4.
  - write to the status offset.
- On error: no register change, no o_wr_pulse, o_prdata=0.
- Reads never have side effects.
- Reset mid-transfer: returns to IDLE; a pending write is discarded; outputs take reset values on the same edge.

Decomposition:
- Shared package apb_slv_pkg: state_t enum {IDLE, WAIT, READY} (2-bit); STATUS_OFFSET function of NUM_REGS; err-code localparams.
- One sub-module, apb_slv_addr_decode (combinational): maps the latched address and direction to {hit_rw, hit_status, idx, err}.

Test Plan:
1. Reset, then WAIT_CYCLES=0, read 0x00 -> pready=1 in first access cycle, prdata=0x00000000, pslverr=0.
2. Write 0xDEADBEEF to 0x04, then read 0x04 -> o_wr_pulse=1 with o_wr_idx=1; o_regs[63:32]=0xDEADBEEF; read returns 0xDEADBEEF.
3. WAIT_CYCLES=2, write 0x12345678 to 0x08 -> pready low for 2 access cycles and high on the 3rd; register updates only after the 3rd.
4. Write to 0x40 and to 0x06 -> pslverr=1 with pready, o_regs unchanged, no o_wr_pulse; a subsequent read of 0x04 is still correct.
5. i_status=0x0000A5A5, read 0x20 -> prdata=0x0000A5A5; write 0x20 -> pslverr=1, no effect.
6. WAIT_CYCLES=3, assert i_rst_apb during WAIT of a write of 0xFFFFFFFF to 0x0C -> pready=0, o_regs all 0, next transfer completes normally; also psel dropped mid-WAIT -> no write.
